muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file: consumes `read_data1`/`read_data2` as `rs1_data`/`rs2_data`.
- Sits directly upstream of the register file write port: drives `reg_write`/`write_reg`/`write_data` for one cycle when a result is ready.
- Radix-2 shift-add/shift-subtract datapath, one operation in flight at a time.

---
 rtl/muldiv_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide execution unit. It takes operands from the
// register-file read ports and issues a single one-cycle write to the
// register-file write port when the result is ready. The datapath is radix-2:
// multiplies use shift-add and divides use restoring shift-subtract. Only one
// operation is in flight at a time.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   When defined, multiplies (op[2]=0) compute the full product in the accept
//   cycle and skip CALC. Divides are unchanged. Results are identical in both
//   builds; only the latency differs.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active high, aborts any in-flight op
//   start_i      request pulse, sampled only while idle
//   op_i         funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1_data_i   operand A (multiplicand / dividend)
//   rs2_data_i   operand B (multiplier / divisor)
//   rd_i         destination register index
//   busy_o       high from the cycle after accept through the DONE cycle
//   done_o       one-cycle result-valid pulse
//   reg_write_o  register-file write enable (low when rd = 0)
//   write_reg_o  destination index
//   write_data_o result
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [4:0]      rd_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            reg_write_o,
   output logic [4:0]      write_reg_o,
   output logic [XLEN-1:0] write_data_o
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Sign correction and result selection from the final 64-bit accumulator.
   // Multiplies negate the full product before the high half is picked;
   // divides hold {remainder, quotient} in the accumulator.
   function automatic logic [XLEN-1:0] finalize(input logic [2:0]        op,
                                                input logic              neg,
                                                input logic [2*XLEN-1:0] acc);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   qr;
      logic [XLEN-1:0]   res;
      prod = neg ? -acc : acc;
      qr   = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      if (!op[2]) begin
         res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end else begin
         res = neg ? -qr : qr;
      end
      return res;
   endfunction

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   opb_q, opb_d;      // multiplicand or divisor magnitude
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, done_q, done_d, wen_q, wen_d;
   logic [4:0]        wreg_q, wreg_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;

   logic              sign_a_s, sign_b_s, neg_a_s, neg_b_s, res_neg_s;
   logic [XLEN-1:0]   mag_a_s, mag_b_s, special_s;
   logic              div_zero_s, div_ovf_s;
   logic [XLEN:0]     mul_sum_s, rem_sh_s;
   logic              div_ge_s;
   logic [XLEN-1:0]   rem_new_s;
   logic [2*XLEN-1:0] step_s;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod_s;
`endif

   // Accept-time operand decode: signedness, magnitudes, special cases.
   always_comb begin
      sign_a_s   = (op_i[2] & ~op_i[0]) | (op_i == 3'b001) | (op_i == 3'b010);
      sign_b_s   = (op_i[2] & ~op_i[0]) | (op_i == 3'b001);
      neg_a_s    = sign_a_s & rs1_data_i[XLEN-1];
      neg_b_s    = sign_b_s & rs2_data_i[XLEN-1];
      mag_a_s    = neg_a_s ? -rs1_data_i : rs1_data_i;
      mag_b_s    = neg_b_s ? -rs2_data_i : rs2_data_i;
      // Remainder takes the dividend's sign; everything else signA^signB.
      res_neg_s  = (op_i[2] & op_i[1]) ? neg_a_s : (neg_a_s ^ neg_b_s);
      div_zero_s = op_i[2] & (rs2_data_i == {XLEN{1'b0}});
      div_ovf_s  = op_i[2] & ~op_i[0]
                   & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                   & (rs2_data_i == {XLEN{1'b1}});
      if (div_ovf_s) begin
         special_s = op_i[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
      end else begin
         special_s = op_i[1] ? rs1_data_i : {XLEN{1'b1}};
      end
`ifdef MULDIV_FAST_MUL_EN
      // Low 2*XLEN bits of the sign-extended product are the exact result.
      fast_prod_s = {{XLEN{neg_a_s}}, rs1_data_i} * {{XLEN{neg_b_s}}, rs2_data_i};
`endif
   end

   // One radix-2 iteration for both multiply and divide.
   always_comb begin
      mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
      rem_sh_s  = acc_q[2*XLEN-1:XLEN-1];
      div_ge_s  = (rem_sh_s >= {1'b0, opb_q});
      // The true difference is below 2^XLEN, so XLEN-bit wrap is exact.
      rem_new_s = div_ge_s ? (rem_sh_s[XLEN-1:0] - opb_q) : rem_sh_s[XLEN-1:0];
      if (op_q[2]) begin
         step_s = {rem_new_s, acc_q[XLEN-2:0], div_ge_s};
      end else begin
         step_s = {mul_sum_s, acc_q[XLEN-1:1]};
      end
   end

   // Next-state and next-output logic of the IDLE/CALC/DONE controller.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      neg_d   = neg_q;
      rd_d    = rd_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      wen_d   = 1'b0;
      wreg_d  = 5'd0;
      wdata_d = {XLEN{1'b0}};
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               op_d  = op_i;
               neg_d = res_neg_s;
               rd_d  = rd_i;
               cnt_d = {CW{1'b0}};
               opb_d = op_i[2] ? mag_b_s : mag_a_s;
               acc_d = {{XLEN{1'b0}}, (op_i[2] ? mag_a_s : mag_b_s)};
               if (div_zero_s | div_ovf_s) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  wen_d   = (rd_i != 5'd0);
                  wreg_d  = rd_i;
                  wdata_d = special_s;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!op_i[2]) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  wen_d   = (rd_i != 5'd0);
                  wreg_d  = rd_i;
                  wdata_d = finalize(op_i, 1'b0, fast_prod_s);
               end
`endif
               else begin
                  state_d = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            acc_d = step_s;
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == CW'(ITER - 1)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               wen_d   = (rd_q != 5'd0);
               wreg_d  = rd_q;
               wdata_d = finalize(op_q, neg_q, step_s);
            end else begin
               state_d = S_CALC;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered-output update with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         op_q    <= 3'd0;
         neg_q   <= 1'b0;
         rd_q    <= 5'd0;
         opb_q   <= {XLEN{1'b0}};
         acc_q   <= {(2*XLEN){1'b0}};
         cnt_q   <= {CW{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wen_q   <= 1'b0;
         wreg_q  <= 5'd0;
         wdata_q <= {XLEN{1'b0}};
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         rd_q    <= rd_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= done_d;
         wen_q   <= wen_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign reg_write_o  = wen_q;
   assign write_reg_o  = wreg_q;
   assign write_data_o = wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed, table-driven bench for muldiv_unit with hand-computed results and
// latencies, plus hand-written sequences for ignored starts and reset abort.
// Reads MULDIV_FAST_MUL_EN to pick the expected multiply latency.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs1, rs2;
   logic [4:0]  rd;
   logic        busy, done, reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;

   int errors = 0;
   int checks = 0;

   muldiv_unit dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .op_i         (op),
      .rs1_data_i   (rs1),
      .rs2_data_i   (rs2),
      .rd_i         (rd),
      .busy_o       (busy),
      .done_o       (done),
      .reg_write_o  (reg_write),
      .write_reg_o  (write_reg),
      .write_data_o (write_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[20];

   // Issue one request and wait (bounded) for its done pulse.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, output int lat, output logic [31:0] data,
                         output logic [4:0] wreg, output logic wen,
                         output logic busy1, output logic after);
      @(negedge clk);
      op = o; rs1 = a; rs2 = b; rd = d; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; rd = 5'd31; op = 3'b111;
      lat = 0; data = 32'h0; wreg = 5'd0; wen = 1'b0; busy1 = 1'b0; after = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 1) busy1 = busy;
         if (done) begin
            lat = c; data = write_data; wreg = write_reg; wen = reg_write;
            break;
         end
      end
      if (lat != 0) begin
         @(negedge clk);
         after = busy | done | reg_write;
      end
   endtask

   initial begin
      int          lat;
      logic [31:0] data;
      logic [4:0]  wreg;
      logic        wen, busy1, after;
      int          pulses;
      logic [31:0] pdata;
      logic [4:0]  preg;
      int          writes;

      vecs[0]  = '{3'b000, 32'd7,          32'd6,          5'd10, 32'd42,          MUL_LAT};
      vecs[1]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,   MUL_LAT};
      vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,   MUL_LAT};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF,   MUL_LAT};
      vecs[4]  = '{3'b001, 32'h8000_0000,  32'h8000_0000,  5'd4,  32'h4000_0000,   MUL_LAT};
      vecs[5]  = '{3'b000, 32'hFFFF_FFFD,  32'd5,          5'd5,  32'hFFFF_FFF1,   MUL_LAT};
      vecs[6]  = '{3'b010, 32'd2,          32'hFFFF_FFFF,  5'd6,  32'h0000_0001,   MUL_LAT};
      vecs[7]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,   DIV_LAT};
      vecs[8]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,   DIV_LAT};
      vecs[9]  = '{3'b101, 32'd100,        32'd0,          5'd5,  32'hFFFF_FFFF,   1};
      vecs[10] = '{3'b111, 32'd100,        32'd0,          5'd5,  32'd100,         1};
      vecs[11] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000,   1};
      vecs[12] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h0000_0000,   1};
      vecs[13] = '{3'b101, 32'd99,         32'd10,         5'd0,  32'd9,           DIV_LAT};
      vecs[14] = '{3'b111, 32'd99,         32'd10,         5'd6,  32'd9,           DIV_LAT};
      vecs[15] = '{3'b100, 32'd7,          32'hFFFF_FFFE,  5'd9,  32'hFFFF_FFFD,   DIV_LAT};
      vecs[16] = '{3'b110, 32'd7,          32'hFFFF_FFFE,  5'd9,  32'h0000_0001,   DIV_LAT};
      vecs[17] = '{3'b101, 32'hFFFF_FFFF,  32'd1,          5'd12, 32'hFFFF_FFFF,   DIV_LAT};
      vecs[18] = '{3'b110, 32'hFFFF_FFFB,  32'd0,          5'd13, 32'hFFFF_FFFB,   1};
      vecs[19] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h0000_0000,   DIV_LAT};

      rst = 1'b1; start = 1'b0; op = 3'b000; rs1 = 32'h0; rs2 = 32'h0; rd = 5'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_done", {31'h0, done}, 32'h0);
      check("reset_reg_write", {31'h0, reg_write}, 32'h0);
      check("reset_write_reg", {27'h0, write_reg}, 32'h0);
      check("reset_write_data", write_data, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, lat, data, wreg, wen, busy1, after);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_data", i), data, vecs[i].exp);
         check($sformatf("v%0d_write_reg", i), {27'h0, wreg}, {27'h0, vecs[i].rd});
         check($sformatf("v%0d_reg_write", i), {31'h0, wen}, {31'h0, (vecs[i].rd != 5'd0)});
         check($sformatf("v%0d_busy_after_accept", i), {31'h0, busy1}, 32'h1);
         check($sformatf("v%0d_idle_after_done", i), {31'h0, after}, 32'h0);
      end

      // Starts while busy and in the DONE cycle are both ignored.
      @(negedge clk);
      op = 3'b100; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd10; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      pulses = 0; pdata = 32'h0; preg = 5'd0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            if (pulses == 1) begin
               pdata = write_data; preg = write_reg;
            end
         end
         op = 3'b101; rs1 = 32'd50; rs2 = 32'd5; rd = 5'd7;
         start = (c == 5) || done;
      end
      start = 1'b0;
      check("ignored_start_pulses", pulses, 32'd1);
      check("ignored_start_data", pdata, 32'd14);
      check("ignored_start_write_reg", {27'h0, preg}, 32'd10);

      // Reset in the middle of an operation aborts it without a write.
      @(negedge clk);
`ifdef MULDIV_FAST_MUL_EN
      op = 3'b101; rs1 = 32'd9; rs2 = 32'd3;
`else
      op = 3'b000; rs1 = 32'd3; rs2 = 32'd3;
`endif
      rd = 5'd11; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      writes = 0;
      for (int c = 1; c < 10; c++) begin
         @(negedge clk);
         if (reg_write || done) writes++;
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_done", {31'h0, done}, 32'h0);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (reg_write || done) writes++;
      end
      check("abort_no_write", writes, 32'd0);

      run_op(3'b000, 32'd2, 32'd2, 5'd3, lat, data, wreg, wen, busy1, after);
      check("post_reset_latency", lat, MUL_LAT);
      check("post_reset_data", data, 32'd4);
      check("post_reset_reg_write", {31'h0, wen}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
